ex_stage: RTL

Execute stage of the RV32I 5-stage pipeline. Sits directly downstream of the ID/EX pipeline register and consumes its E-suffixed outputs.
- Performs operand forwarding, ALU operation, branch resolution and jump-target generation.
- Registers the results into an internal EX/MEM pipeline register feeding the memory stage.
- Drives the PC redirect back to fetch.

---
 rtl/ex_stage.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// RV32I execute stage: forwarding, ALU, branch/jump resolution and the EX/MEM pipeline register.
// Optional macro EX_FWD_EN compiles in operand forwarding from the M and W stages.
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MemReadE,
    input  logic            MemWriteE,
    input  logic            ALUSrcE,
    input  logic            JumpE,
    input  logic            RegWriteE,
    input  logic            BranchE,
    input  logic            MuxjalrE,
    input  logic [3:0]      ALUOpE,
    input  logic [2:0]      WriteBackE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RdE,
    input  logic [4:0]      Rs1E,
    input  logic [4:0]      Rs2E,
    input  logic [4:0]      RdW,
    input  logic            RegWriteW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            StallM,
    input  logic            FlushM,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            MemReadM,
    output logic            MemWriteM,
    output logic            RegWriteM,
    output logic [2:0]      WriteBackM,
    output logic [2:0]      funct3M,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [4:0]      RdM
);

    logic            r_mem_read, r_mem_write, r_reg_write;
    logic [2:0]      r_write_back, r_funct3;
    logic [XLEN-1:0] r_alu_result, r_write_data, r_pc_plus4;
    logic [4:0]      r_rd;

    logic [XLEN-1:0] w_src_a, w_fwd_b, w_src_b, w_alu_result, w_jalr_sum;
    logic [4:0]      w_shamt;
    logic            w_cond;

`ifdef EX_FWD_EN
    logic [XLEN-1:0] w_m_value;

    // Operand bypass: M stage wins over W stage; x0 is never forwarded.
    always_comb begin
        w_m_value = (r_write_back == 3'b010) ? r_pc_plus4 : r_alu_result;
        if (r_reg_write && (r_rd != 5'd0) && (r_rd == Rs1E)) begin
            w_src_a = w_m_value;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
            w_src_a = ResultW;
        end else begin
            w_src_a = RD1E;
        end
        if (r_reg_write && (r_rd != 5'd0) && (r_rd == Rs2E)) begin
            w_fwd_b = w_m_value;
        end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
            w_fwd_b = ResultW;
        end else begin
            w_fwd_b = RD2E;
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{RdW, RegWriteW, ResultW, Rs1E, Rs2E};

    // Without bypassing the register-file operands are used directly.
    always_comb begin
        w_src_a = RD1E;
        w_fwd_b = RD2E;
    end
`endif

    assign w_src_b = ALUSrcE ? ImmExtE : w_fwd_b;
    assign w_shamt = w_src_b[4:0];

    // ALU operation select.
    always_comb begin
        w_alu_result = {XLEN{1'b0}};
        case (ALUOpE)
            4'b0000: w_alu_result = w_src_a + w_src_b;
            4'b0001: w_alu_result = w_src_a - w_src_b;
            4'b0010: w_alu_result = w_src_a << w_shamt;
            4'b0011: w_alu_result = {{(XLEN-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
            4'b0100: w_alu_result = {{(XLEN-1){1'b0}}, (w_src_a < w_src_b)};
            4'b0101: w_alu_result = w_src_a ^ w_src_b;
            4'b0110: w_alu_result = w_src_a >> w_shamt;
            4'b0111: w_alu_result = $signed(w_src_a) >>> w_shamt;
            4'b1000: w_alu_result = w_src_a | w_src_b;
            4'b1001: w_alu_result = w_src_a & w_src_b;
            4'b1010: w_alu_result = w_src_b;
            4'b1011: w_alu_result = PCE + w_src_b;
            default: w_alu_result = {XLEN{1'b0}};
        endcase
    end

    // Branch condition compares the forwarded rs1/rs2 values, never the immediate.
    always_comb begin
        w_cond = 1'b0;
        case (funct3E)
            3'b000:  w_cond = (w_src_a == w_fwd_b);
            3'b001:  w_cond = (w_src_a != w_fwd_b);
            3'b100:  w_cond = ($signed(w_src_a) < $signed(w_fwd_b));
            3'b101:  w_cond = ($signed(w_src_a) >= $signed(w_fwd_b));
            3'b110:  w_cond = (w_src_a < w_fwd_b);
            3'b111:  w_cond = (w_src_a >= w_fwd_b);
            default: w_cond = 1'b0;
        endcase
    end

    assign w_jalr_sum = w_src_a + ImmExtE;
    assign PCSrcE     = JumpE | (BranchE & w_cond);
    assign PCTargetE  = MuxjalrE ? (w_jalr_sum & 32'hFFFF_FFFE) : (PCE + ImmExtE);

    // EX/MEM register: reset > flush > stall > load.
    always_ff @(posedge clk) begin
        if (!reset || FlushM) begin
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_reg_write  <= 1'b0;
            r_write_back <= 3'b000;
            r_funct3     <= 3'b000;
            r_alu_result <= {XLEN{1'b0}};
            r_write_data <= {XLEN{1'b0}};
            r_pc_plus4   <= {XLEN{1'b0}};
            r_rd         <= 5'd0;
        end else if (!StallM) begin
            r_mem_read   <= MemReadE;
            r_mem_write  <= MemWriteE;
            r_reg_write  <= RegWriteE;
            r_write_back <= WriteBackE;
            r_funct3     <= funct3E;
            r_alu_result <= w_alu_result;
            r_write_data <= w_fwd_b;
            r_pc_plus4   <= PCPlus4E;
            r_rd         <= RdE;
        end
    end

    assign MemReadM   = r_mem_read;
    assign MemWriteM  = r_mem_write;
    assign RegWriteM  = r_reg_write;
    assign WriteBackM = r_write_back;
    assign funct3M    = r_funct3;
    assign ALUResultM = r_alu_result;
    assign WriteDataM = r_write_data;
    assign PCPlus4M   = r_pc_plus4;
    assign RdM        = r_rd;

endmodule
